// File: rtl/gray_pattern_gen.sv
// gray_pattern_gen
//
// Gray-code stimulus source for the Gray-to-binary display path. A binary
// count is loaded from switches on a push-button edge. It is then held, or
// stepped up or down once every TICK_DIV cycles. The registered Gray word
// changes exactly one bit per counting step, including wrap-around.
//
// Ports:
//   clk       system clock, all state updates on its rising edge
//   rst       synchronous active-high reset, highest priority
//   bin_in    [WIDTH] binary value taken from the switches on a load
//   load_btn  asynchronous button level; each clean rising edge is one load
//   mode      [2] 00 hold, 01 count up, 10 count down, 11 hold
//   gray_out  [WIDTH] registered Gray encoding of the current count
//   bin_out   [WIDTH] registered current binary count
//   step      one-cycle pulse on the cycle the outputs change (step or load)
//   run       high while the state machine is in RUN_UP or RUN_DOWN
module gray_pattern_gen #(
    parameter int WIDTH    = 4,
    parameter int TICK_DIV = 25000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] bin_in,
    input  logic             load_btn,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] gray_out,
    output logic [WIDTH-1:0] bin_out,
    output logic             step,
    output logic             run
);

    localparam int            PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] TC = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        HOLD     = 2'b00,
        RUN_UP   = 2'b01,
        RUN_DOWN = 2'b10
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [PW-1:0]    presc_q;
    logic [PW-1:0]    presc_d;
    logic [WIDTH-1:0] bin_d;
    logic             upd;
    logic             tick;
    logic             load_evt;

    // Button synchronizer (p0, p1) followed by the previous-sample flop (p2).
    logic load_sync_p0;
    logic load_sync_p1;
    logic load_sync_p2;

    function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    assign run = (state_q != HOLD);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= HOLD;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, prescaler and count update
    always_comb begin
        state_d  = HOLD;
        bin_d    = bin_out;
        upd      = 1'b0;
        presc_d  = presc_q + PW'(1);

        case (mode)
            2'b01:   state_d = RUN_UP;
            2'b10:   state_d = RUN_DOWN;
            default: state_d = HOLD;
        endcase

        load_evt = load_sync_p1 & ~load_sync_p2;
        tick     = (state_q != HOLD) && (presc_q == TC);

        // A load overrides a coincident terminal count: no increment is applied.
        if (load_evt) begin
            bin_d = bin_in;
            upd   = 1'b1;
        end else if (tick) begin
            upd   = 1'b1;
            bin_d = (state_q == RUN_UP) ? bin_out + WIDTH'(1) : bin_out - WIDTH'(1);
        end

        // Prescaler parks at zero in HOLD and restarts on any load, wrap or
        // state change, so the first step lands TICK_DIV cycles after entry.
        if (load_evt || tick || (state_q == HOLD) || (state_d != state_q)) begin
            presc_d = '0;
        end
    end

    // Synchronizer, prescaler and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            load_sync_p0 <= 1'b0;
            load_sync_p1 <= 1'b0;
            load_sync_p2 <= 1'b0;
            presc_q      <= '0;
            bin_out      <= '0;
            gray_out     <= '0;
            step         <= 1'b0;
        end else begin
            load_sync_p0 <= load_btn;
            load_sync_p1 <= load_sync_p0;
            load_sync_p2 <= load_sync_p1;
            presc_q      <= presc_d;
            step         <= upd;
            // Both outputs come from the same next value so they never disagree.
            if (upd) begin
                bin_out  <= bin_d;
                gray_out <= to_gray(bin_d);
            end
        end
    end

endmodule
